nios2_system_sw_poller: RTL and testbench

Avalon-MM master that periodically reads the switch input PIO (register 0) and turns its 10-bit value into registered, change-qualified outputs for fabric logic. Sits beside the Nios II in `nios2_system` as a second initiator on the PIO's s1 slave, so hardware can react to switch changes without CPU polling. Issues one single-word read per poll interval, honours waitrequest and a fixed read latency, and raises a one-cycle event when the sampled value changes.

---
 rtl/nios2_system_sw_poller.sv | 167 ++++++++++++++++
 tb/tb_nios2_system_sw_poller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nios2_system_sw_poller.sv
// Avalon-MM read master that polls the switch PIO data register and publishes change-qualified switch state.
// Optional confirm-on-second-poll filtering is enabled with `define SW_POLLER_DEBOUNCE_EN.
module nios2_system_sw_poller #(
    parameter int DATA_W       = 10,
    parameter int POLL_DIV     = 50000,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    output logic [1:0]        avm_address_o,
    output logic              avm_read_o,
    input  logic              avm_waitrequest_i,
    input  logic [31:0]       avm_readdata_i,
    output logic [DATA_W-1:0] sw_value_o,
    output logic [DATA_W-1:0] sw_changed_o,
    output logic              change_pulse_o,
    output logic              sample_valid_o
);

    localparam logic [23:0] CNT_RELOAD = 24'(POLL_DIV - 1);
    localparam logic [2:0]  LAT_LOAD   = 3'(READ_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [23:0]         cnt_q, cnt_d;
    logic [2:0]          lat_q, lat_d;
    logic                read_q, read_d;
    logic [DATA_W-1:0]   val_q, val_d;
    logic [DATA_W-1:0]   chg_q, chg_d;
    logic                pulse_q, pulse_d;
    logic                valid_q, valid_d;
    logic                take;
    logic [DATA_W-1:0]   sample;
`ifdef SW_POLLER_DEBOUNCE_EN
    logic [DATA_W-1:0]   cand_q, cand_d;
    logic                candv_q, candv_d;
`endif

    // Upper readdata bits carry nothing of interest on this PIO.
    logic unused_readdata_hi;
    assign unused_readdata_hi = ^avm_readdata_i[31:DATA_W];

    assign sample = avm_readdata_i[DATA_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        val_d   = val_q;
        chg_d   = chg_q;
        pulse_d = 1'b0;
        valid_d = valid_q;
        take    = 1'b0;
`ifdef SW_POLLER_DEBOUNCE_EN
        cand_d  = cand_q;
        candv_d = candv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!enable_i) begin
                    cnt_d = CNT_RELOAD;
                end else if (cnt_q == 24'd0) begin
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q - 24'd1;
                end
            end
            S_REQ: begin
                if (!avm_waitrequest_i) begin
                    state_d = S_WAIT;
                    lat_d   = LAT_LOAD;
                end
            end
            S_WAIT: begin
                if (lat_q == 3'd1) begin
                    take    = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_RELOAD;
            end
        endcase

        if (take) begin
            if (!valid_q) begin
                // First sample is a baseline, not a change.
                val_d   = sample;
                chg_d   = '0;
                valid_d = 1'b1;
`ifdef SW_POLLER_DEBOUNCE_EN
                candv_d = 1'b0;
`endif
            end else if (sample != val_q) begin
`ifdef SW_POLLER_DEBOUNCE_EN
                if (candv_q && (sample == cand_q)) begin
                    val_d   = sample;
                    chg_d   = val_q ^ sample;
                    pulse_d = 1'b1;
                    candv_d = 1'b0;
                end else begin
                    cand_d  = sample;
                    candv_d = 1'b1;
                end
`else
                val_d   = sample;
                chg_d   = val_q ^ sample;
                pulse_d = 1'b1;
`endif
            end else begin
`ifdef SW_POLLER_DEBOUNCE_EN
                candv_d = 1'b0;
`endif
            end
        end

        read_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_RELOAD;
            lat_q   <= 3'd0;
            read_q  <= 1'b0;
            val_q   <= '0;
            chg_q   <= '0;
            pulse_q <= 1'b0;
            valid_q <= 1'b0;
`ifdef SW_POLLER_DEBOUNCE_EN
            cand_q  <= '0;
            candv_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            read_q  <= read_d;
            val_q   <= val_d;
            chg_q   <= chg_d;
            pulse_q <= pulse_d;
            valid_q <= valid_d;
`ifdef SW_POLLER_DEBOUNCE_EN
            cand_q  <= cand_d;
            candv_q <= candv_d;
`endif
        end
    end

    assign avm_address_o  = 2'b00;
    assign avm_read_o     = read_q;
    assign sw_value_o     = val_q;
    assign sw_changed_o   = chg_q;
    assign change_pulse_o = pulse_q;
    assign sample_valid_o = valid_q;

endmodule

// File: tb/tb_nios2_system_sw_poller.sv
// Directed and randomized bench for nios2_system_sw_poller with a transaction-level reference model.
module tb_nios2_system_sw_poller;

    localparam int PD = 8;
    localparam int RL = 1;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [1:0]    avm_address;
    logic          avm_read;
    logic          avm_waitrequest;
    logic [31:0]   avm_readdata;
    logic [DW-1:0] sw_value;
    logic [DW-1:0] sw_changed;
    logic          change_pulse;
    logic          sample_valid;

    nios2_system_sw_poller #(.DATA_W(DW), .POLL_DIV(PD), .READ_LATENCY(RL)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .enable_i          (enable),
        .avm_address_o     (avm_address),
        .avm_read_o        (avm_read),
        .avm_waitrequest_i (avm_waitrequest),
        .avm_readdata_i    (avm_readdata),
        .sw_value_o        (sw_value),
        .sw_changed_o      (sw_changed),
        .change_pulse_o    (change_pulse),
        .sample_valid_o    (sample_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Reference model state: what the switch outputs should be after each accepted sample.
    logic [DW-1:0] m_val, m_chg, m_cand;
    bit            m_valid, m_candv;

    int last_rise = -1;
    int exp_gap   = 0;
    int en_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_val = '0; m_chg = '0; m_cand = '0; m_valid = 0; m_candv = 0;
    endtask

    function automatic bit model_apply(input logic [DW-1:0] s);
        if (!m_valid) begin
            m_val = s; m_chg = '0; m_valid = 1; m_candv = 0;
            return 1'b0;
        end
        if (s == m_val) begin
            m_candv = 0;
            return 1'b0;
        end
`ifdef SW_POLLER_DEBOUNCE_EN
        if (!(m_candv && s == m_cand)) begin
            m_cand = s; m_candv = 1;
            return 1'b0;
        end
        m_candv = 0;
`endif
        m_chg = m_val ^ s;
        m_val = s;
        return 1'b1;
    endfunction

    task automatic wait_read(output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (avm_read === 1'b1) begin
                ok = 1;
                return;
            end
            @(negedge clk);
        end
    endtask

    // One complete poll: slave presents v, stalls nwait cycles; optionally drops enable in WAIT.
    task automatic poll(input logic [DW-1:0] v, input int nwait, input bit drop_en, input bit chk_gap);
        bit          ok;
        bit          exp_pulse;
        logic [31:0] r;
        r = $urandom();
        avm_readdata    = {r[31:DW], v};
        avm_waitrequest = (nwait > 0);
        wait_read(ok);
        chk("read_seen", {31'd0, ok}, 32'd1);
        if (!ok) return;
        if (chk_gap && last_rise >= 0) chk("read_period", cyc - last_rise, exp_gap);
        last_rise = cyc;
        exp_gap   = PD + 1 + RL + nwait;
        for (int i = 0; i < nwait; i++) begin
            chk("read_held", {31'd0, avm_read}, 32'd1);
            chk("addr_held", {30'd0, avm_address}, 32'd0);
            @(negedge clk);
        end
        chk("read_accept", {31'd0, avm_read}, 32'd1);
        chk("addr_accept", {30'd0, avm_address}, 32'd0);
        avm_waitrequest = 1'b0;
        @(negedge clk);
        chk("read_dropped", {31'd0, avm_read}, 32'd0);
        if (drop_en) enable = 1'b0;
        repeat (RL) @(negedge clk);
        exp_pulse = model_apply(v);
        chk("sw_value", {22'd0, sw_value}, {22'd0, m_val});
        chk("sw_changed", {22'd0, sw_changed}, {22'd0, m_chg});
        chk("change_pulse", {31'd0, change_pulse}, {31'd0, exp_pulse});
        chk("sample_valid", {31'd0, sample_valid}, 32'd1);
        @(negedge clk);
        chk("pulse_one_cycle", {31'd0, change_pulse}, 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_read"},   {31'd0, avm_read}, 32'd0);
        chk({tag, "_addr"},   {30'd0, avm_address}, 32'd0);
        chk({tag, "_value"},  {22'd0, sw_value}, 32'd0);
        chk({tag, "_chg"},    {22'd0, sw_changed}, 32'd0);
        chk({tag, "_pulse"},  {31'd0, change_pulse}, 32'd0);
        chk({tag, "_valid"},  {31'd0, sample_valid}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            ok;
        bit            seen;
        logic [DW-1:0] v;
        reset = 1'b1; enable = 1'b1; avm_waitrequest = 1'b0; avm_readdata = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // Baseline, steady value, single-bit change, then steady again.
        poll(10'h2A5, 0, 0, 1);
        poll(10'h2A5, 0, 0, 1);
        poll(10'h2A4, 0, 0, 1);
        poll(10'h2A4, 0, 0, 1);
        // Three cycles of waitrequest.
        poll(10'h2A4, 3, 0, 1);
        poll(10'h0F0, 0, 0, 1);

        // Enable dropped during WAIT: sample still applied, then silence until re-enable.
        poll(10'h155, 0, 1, 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (avm_read) seen = 1;
        end
        chk("no_read_disabled", {31'd0, seen}, 32'd0);
        enable = 1'b1;
        en_cyc = cyc;
        poll(10'h155, 0, 0, 0);
        chk("reenable_delay", last_rise - en_cyc, PD);

        // Reset in the middle of a stalled request.
        avm_waitrequest = 1'b1;
        wait_read(ok);
        chk("rst_read_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        reset = 1'b0;
        avm_waitrequest = 1'b0;
        model_reset();
        last_rise = -1;
        poll(10'h3C3, 0, 0, 1);
        poll(10'h3C3, 0, 0, 1);

        // Random values and stalls; about half repeat the previous value.
        for (int i = 0; i < 16; i++) begin
            v = ($urandom_range(0, 1) == 0) ? m_val : DW'($urandom());
            poll(v, $urandom_range(0, 3), 0, 1);
        end

`ifdef SW_POLLER_DEBOUNCE_EN
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        last_rise = -1;
        poll(10'h000, 0, 0, 1);
        poll(10'h3FF, 0, 0, 1);
        poll(10'h000, 0, 0, 1);
        poll(10'h3FF, 0, 0, 1);
        chk("db_hold_value", {22'd0, sw_value}, 32'h000);
        poll(10'h3FF, 0, 0, 1);
        chk("db_final_value", {22'd0, sw_value}, 32'h3FF);
        chk("db_final_chg", {22'd0, sw_changed}, 32'h3FF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
